// File: rtl/vga_overlay_compositor.sv
// vga_overlay_compositor: threshold mask plus NUM_LAYERS prioritised overlay
// layers with per-layer colour, blink and 50% blend. Configuration is
// shadowed and swapped in on the vsync rising edge. Two-cycle pipeline; sync,
// active and frame-start markers travel alongside the pixel.
module vga_overlay_compositor #(
    parameter int PIXEL_WIDTH  = 12,
    parameter int NUM_LAYERS   = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [PIXEL_WIDTH-1:0]            pixel_in,
    input  logic                              hsync_in,
    input  logic                              vsync_in,
    input  logic                              active_in,
    input  logic                              mask_in,
    input  logic [NUM_LAYERS-1:0]             layer_hit_in,
    input  logic                              mask_on_req,
    input  logic [NUM_LAYERS-1:0]             layer_en_req,
    input  logic [NUM_LAYERS-1:0]             layer_blink_req,
    input  logic [NUM_LAYERS-1:0]             layer_blend_req,
    input  logic [NUM_LAYERS*PIXEL_WIDTH-1:0] layer_color_req,
    output logic [PIXEL_WIDTH-1:0]            pixel_out,
    output logic                              hsync_out,
    output logic                              vsync_out,
    output logic                              active_out,
    output logic                              frame_start_out
);
    localparam int CW   = PIXEL_WIDTH / 3;
    localparam int FCW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int LAST = BLINK_FRAMES - 1;

    // Active (shadowed) configuration
    logic                              mask_on;
    logic [NUM_LAYERS-1:0]             en, blink, blend;
    logic [NUM_LAYERS*PIXEL_WIDTH-1:0] color;

    // Frame tracking
    logic           vsync_prev;
    logic [FCW-1:0] frame_cnt;
    logic           blink_phase;
    logic           vs_rise;
    logic [NUM_LAYERS-1:0] eff_en;

    assign vs_rise = vsync_in & ~vsync_prev;
    assign eff_en  = en & ~(blink & {NUM_LAYERS{blink_phase}});

    // Config swap and blink counter, both stepped once per vsync rising edge
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mask_on     <= 1'b0;
            en          <= '0;
            blink       <= '0;
            blend       <= '0;
            color       <= '0;
            vsync_prev  <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            if (vs_rise) begin
                mask_on <= mask_on_req;
                en      <= layer_en_req;
                blink   <= layer_blink_req;
                blend   <= layer_blend_req;
                color   <= layer_color_req;
                if (frame_cnt == LAST[FCW-1:0]) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 1. The layer config is captured with the pixel so a pixel that
    // enters on the vs_rise cycle is still composited with the old config,
    // even though the active config has already swapped by stage 2.
    logic [PIXEL_WIDTH-1:0]            masked_s1;
    logic [NUM_LAYERS-1:0]             hit_s1, blend_s1;
    logic [NUM_LAYERS*PIXEL_WIDTH-1:0] color_s1;
    logic                              hsync_s1, vsync_s1, active_s1, vsr_s1;

    // Stage 1: mask, qualify hits with effective enables, capture config
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            masked_s1 <= '0;
            hit_s1    <= '0;
            blend_s1  <= '0;
            color_s1  <= '0;
            hsync_s1  <= 1'b0;
            vsync_s1  <= 1'b0;
            active_s1 <= 1'b0;
            vsr_s1    <= 1'b0;
        end else begin
            masked_s1 <= (mask_on & ~mask_in) ? '0 : pixel_in;
            hit_s1    <= layer_hit_in & eff_en;
            blend_s1  <= blend;
            color_s1  <= color;
            hsync_s1  <= hsync_in;
            vsync_s1  <= vsync_in;
            active_s1 <= active_in;
            vsr_s1    <= vs_rise;
        end
    end

    // Winner select: ascending scan so the highest hitting index wins
    logic                   found, win_blend;
    logic [PIXEL_WIDTH-1:0] win_color, blend_pix;

    always_comb begin
        found     = 1'b0;
        win_blend = 1'b0;
        win_color = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (hit_s1[i]) begin
                found     = 1'b1;
                win_blend = blend_s1[i];
                win_color = color_s1[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

    // 50% blend per channel: (a+b)>>1 == (a>>1)+(b>>1)+(a0&b0), which fits in
    // CW bits without a carry bit and truncates exactly like the wide form.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [CW-1:0] a, b;
        assign a = masked_s1[c*CW +: CW];
        assign b = win_color[c*CW +: CW];
        assign blend_pix[c*CW +: CW] = {1'b0, a[CW-1:1]} + {1'b0, b[CW-1:1]}
                                     + {{(CW-1){1'b0}}, a[0] & b[0]};
    end

    // Stage 2: output register, blanked outside the active region
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_out       <= '0;
            hsync_out       <= 1'b0;
            vsync_out       <= 1'b0;
            active_out      <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            if (!active_s1)     pixel_out <= '0;
            else if (!found)    pixel_out <= masked_s1;
            else if (win_blend) pixel_out <= blend_pix;
            else                pixel_out <= win_color;
            hsync_out       <= hsync_s1;
            vsync_out       <= vsync_s1;
            active_out      <= active_s1;
            frame_start_out <= vsr_s1;
        end
    end
endmodule

// File: tb/tb_vga_overlay_compositor.sv
// Directed bench for vga_overlay_compositor (BLINK_FRAMES=2 so blink is quick).
module tb_vga_overlay_compositor;
    localparam int PW = 12;
    localparam int NL = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [PW-1:0] pixel_in;
    logic          hsync_in, vsync_in, active_in, mask_in;
    logic [NL-1:0] layer_hit_in;
    logic          mask_on_req;
    logic [NL-1:0] layer_en_req, layer_blink_req, layer_blend_req;
    logic [NL*PW-1:0] layer_color_req;
    logic [PW-1:0] pixel_out;
    logic          hsync_out, vsync_out, active_out, frame_start_out;

    int tests = 0;
    int fails = 0;

    vga_overlay_compositor #(.PIXEL_WIDTH(PW), .NUM_LAYERS(NL), .BLINK_FRAMES(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .pixel_in(pixel_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
        .mask_in(mask_in), .layer_hit_in(layer_hit_in),
        .mask_on_req(mask_on_req), .layer_en_req(layer_en_req),
        .layer_blink_req(layer_blink_req), .layer_blend_req(layer_blend_req),
        .layer_color_req(layer_color_req), .pixel_out(pixel_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .active_out(active_out),
        .frame_start_out(frame_start_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 5-cycle vsync pulse followed by 3 idle cycles; exactly one frame_start
    task automatic frame();
        int n = 0;
        vsync_in = 1'b1;
        repeat (5) begin tick(); if (frame_start_out) n++; end
        vsync_in = 1'b0;
        repeat (3) begin tick(); if (frame_start_out) n++; end
        chk("fs_once", n, 1);
    endtask

    initial begin
        rst_in = 1'b1; pixel_in = '0; hsync_in = 0; vsync_in = 0; active_in = 0;
        mask_in = 1'b1; layer_hit_in = '0; mask_on_req = 0; layer_en_req = '0;
        layer_blink_req = '0; layer_blend_req = '0; layer_color_req = '0;
        tick(); tick();
        chk("rst_pix", pixel_out, 0);
        chk("rst_sync", {hsync_out, vsync_out, active_out, frame_start_out}, 0);
        rst_in = 1'b0;

        // exact 2-cycle latency with default pass-through config
        active_in = 1; pixel_in = 12'h123; tick();
        pixel_in = 12'hABC; hsync_in = 1; tick();
        chk("lat_pix_a", pixel_out, 12'h123);
        chk("lat_hs_a", hsync_out, 0);
        pixel_in = 12'h000; hsync_in = 0; tick();
        chk("lat_pix_b", pixel_out, 12'hABC);
        chk("lat_hs_b", hsync_out, 1);
        chk("lat_act", active_out, 1);

        // mask
        mask_on_req = 1; frame(); mask_on_req = 0;
        mask_in = 0; pixel_in = 12'h555; tick(); tick();
        chk("mask_drop", pixel_out, 12'h000);
        mask_in = 1; tick(); tick();
        chk("mask_keep", pixel_out, 12'h555);

        // priority: layers 1 and 3 (mask turned off by this frame)
        layer_en_req = 4'b1010;
        layer_color_req[1*PW +: PW] = 12'h00F;
        layer_color_req[3*PW +: PW] = 12'h0F0;
        frame();
        layer_hit_in = 4'b1010; tick(); tick();
        chk("prio_hi", pixel_out, 12'h0F0);
        // shadowing: request alone has no effect mid-frame
        layer_en_req = 4'b0010; tick(); tick(); tick();
        chk("shadow_hold", pixel_out, 12'h0F0);
        frame();
        chk("prio_lo", pixel_out, 12'h00F);
        layer_hit_in = 4'b1000; tick(); tick();
        chk("disabled_fall", pixel_out, 12'h555);

        // exact swap boundary: pixel on the vs_rise cycle uses old config
        layer_hit_in = 4'b1010; layer_en_req = 4'b1010; tick(); tick();
        vsync_in = 1; tick();
        tick();
        chk("swap_old", pixel_out, 12'h00F);
        chk("swap_fs", {vsync_out, frame_start_out}, 2'b11);
        tick();
        chk("swap_new", pixel_out, 12'h0F0);
        chk("swap_fs_end", frame_start_out, 0);
        vsync_in = 0; tick(); tick();

        // blend
        layer_en_req = 4'b0001; layer_blend_req = 4'b0001;
        layer_color_req = '0; layer_color_req[0 +: PW] = 12'hF00;
        frame();
        layer_hit_in = 4'b0001; pixel_in = 12'h0F0; tick(); tick();
        chk("blend_a", pixel_out, 12'h770);
        layer_color_req[0 +: PW] = 12'hFFF; frame();
        pixel_in = 12'h111; tick(); tick();
        chk("blend_b", pixel_out, 12'h888);
        active_in = 0; tick(); tick();
        chk("inactive_pix", pixel_out, 0);
        chk("inactive_act", active_out, 0);
        active_in = 1;

        // blink: fresh counter, layer 0 solid F00 over base 0F0
        rst_in = 1; tick(); rst_in = 0;
        layer_blend_req = '0; layer_blink_req = 4'b0001;
        layer_color_req[0 +: PW] = 12'hF00; pixel_in = 12'h0F0;
        frame(); chk("blink_f1", pixel_out, 12'hF00);
        frame(); chk("blink_f2", pixel_out, 12'h0F0);
        frame(); chk("blink_f3", pixel_out, 12'h0F0);
        frame(); chk("blink_f4", pixel_out, 12'hF00);
        frame(); chk("blink_f5", pixel_out, 12'hF00);
        frame(); chk("blink_f6", pixel_out, 12'h0F0);

        // mid-frame reset while blink phase is 1
        hsync_in = 1; tick();
        rst_in = 1; tick();
        chk("mrst_pix", pixel_out, 0);
        chk("mrst_hs", hsync_out, 0);
        rst_in = 0; pixel_in = 12'h3C3; tick();
        chk("mrst_first", pixel_out, 0);
        tick();
        chk("mrst_pass", pixel_out, 12'h3C3);
        pixel_in = 12'h0F0; hsync_in = 0;
        frame(); chk("mrst_phase0", pixel_out, 12'hF00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
